// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter that serialises READA/WRITEA commands to the SDRAM controller, with an ack watchdog.
// Define ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              READY,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WR0,
    input  logic              WR1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    output logic              ACK0,
    output logic              ACK1,
    output logic              ERR,
    output logic              GNT,
    output logic              BUSY,
    output logic [2:0]        CMD,
    output logic [ADDR_W-1:0] ADDR,
    input  logic              CMD_ACK
);

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

    localparam logic [2:0]      CMD_NOP    = 3'b000;
    localparam logic [2:0]      CMD_READA  = 3'b001;
    localparam logic [2:0]      CMD_WRITEA = 3'b010;
    localparam logic [TO_W-1:0] TO_LIM     = TO_W'(TIMEOUT);

    state_t            state, state_nxt;
    logic [TO_W-1:0]   wd, wd_nxt;
    logic [2:0]        cmd_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              ack0_nxt, ack1_nxt, err_nxt, gnt_nxt;
    logic              win;

`ifdef ARB_RR_EN
    logic last_gnt, last_gnt_nxt;

    // Under contention the port that did not win last time goes next.
    always_comb begin
        if (REQ0 && REQ1) win = ~last_gnt;
        else              win = ~REQ0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) last_gnt <= 1'b1;
        else          last_gnt <= last_gnt_nxt;
    end
`else
    always_comb win = ~REQ0;
`endif

    always_comb begin
        state_nxt = state;
        wd_nxt    = wd;
        cmd_nxt   = CMD;
        addr_nxt  = ADDR;
        gnt_nxt   = GNT;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        err_nxt   = 1'b0;
`ifdef ARB_RR_EN
        last_gnt_nxt = last_gnt;
`endif
        case (state)
            IDLE: begin
                if (READY && (REQ0 || REQ1)) begin
                    gnt_nxt   = win;
                    addr_nxt  = win ? ADDR1 : ADDR0;
                    cmd_nxt   = (win ? WR1 : WR0) ? CMD_WRITEA : CMD_READA;
                    wd_nxt    = '0;
                    state_nxt = WAIT;
`ifdef ARB_RR_EN
                    last_gnt_nxt = win;
`endif
                end
            end
            WAIT: begin
                wd_nxt = wd + TO_W'(1);
                // An acknowledge in the timeout cycle still counts as success.
                if (CMD_ACK) begin
                    cmd_nxt   = CMD_NOP;
                    ack0_nxt  = ~GNT;
                    ack1_nxt  = GNT;
                    state_nxt = GAP;
                end else if (wd == TO_LIM) begin
                    cmd_nxt   = CMD_NOP;
                    err_nxt   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                cmd_nxt   = CMD_NOP;
                state_nxt = IDLE;
            end
            default: begin
                cmd_nxt   = CMD_NOP;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            wd    <= '0;
            CMD   <= CMD_NOP;
            ADDR  <= '0;
            GNT   <= 1'b0;
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            ERR   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
            CMD   <= cmd_nxt;
            ADDR  <= addr_nxt;
            GNT   <= gnt_nxt;
            ACK0  <= ack0_nxt;
            ACK1  <= ack1_nxt;
            ERR   <= err_nxt;
            BUSY  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a short watchdog (TIMEOUT=8).
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 23;

    logic              CLK = 1'b0;
    logic              RESET_N, READY, REQ0, REQ1, WR0, WR1, CMD_ACK;
    logic [ADDR_W-1:0] ADDR0, ADDR1, ADDR;
    logic              ACK0, ACK1, ERR, GNT, BUSY;
    logic [2:0]        CMD;

    int total = 0;
    int bad   = 0;

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(8), .TO_W(10)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .READY(READY),
        .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .ADDR0(ADDR0), .ADDR1(ADDR1),
        .ACK0(ACK0), .ACK1(ACK1), .ERR(ERR), .GNT(GNT), .BUSY(BUSY),
        .CMD(CMD), .ADDR(ADDR), .CMD_ACK(CMD_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic eg;
        RESET_N = 1'b0; READY = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        WR0 = 1'b0; WR1 = 1'b0; ADDR0 = '0; ADDR1 = '0; CMD_ACK = 1'b0;
        tick(); tick();
        chk("rst_cmd", 32'(CMD), 32'h0);
        chk("rst_addr", 32'(ADDR), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_gnt", 32'(GNT), 32'h0);
        chk("rst_ack", 32'({ACK1, ACK0, ERR}), 32'h0);
        RESET_N = 1'b1;
        tick();

        // single read with ACK three cycles after grant
        READY = 1'b1; REQ0 = 1'b1; WR0 = 1'b0; ADDR0 = 23'h12345;
        tick();
        chk("rd_cmd", 32'(CMD), 32'h1);
        chk("rd_addr", 32'(ADDR), 32'h12345);
        chk("rd_gnt", 32'(GNT), 32'h0);
        chk("rd_busy", 32'(BUSY), 32'h1);
        ADDR0 = 23'h00aaa; WR0 = 1'b1;
        tick();
        chk("rd_hold_cmd1", 32'(CMD), 32'h1);
        chk("rd_hold_addr", 32'(ADDR), 32'h12345);
        tick();
        chk("rd_hold_cmd2", 32'(CMD), 32'h1);
        CMD_ACK = 1'b1;
        tick();
        chk("rd_ack0", 32'(ACK0), 32'h1);
        chk("rd_ack1", 32'(ACK1), 32'h0);
        chk("rd_cmd_nop", 32'(CMD), 32'h0);
        chk("rd_gap_busy", 32'(BUSY), 32'h1);
        CMD_ACK = 1'b0; REQ0 = 1'b0;
        tick();
        chk("rd_ack_pulse", 32'(ACK0), 32'h0);
        chk("rd_idle_busy", 32'(BUSY), 32'h0);

        // init gating
        READY = 1'b0; REQ1 = 1'b1; WR1 = 1'b1; ADDR1 = 23'h7;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("gate_cmd", 32'(CMD), 32'h0);
            chk("gate_busy", 32'(BUSY), 32'h0);
        end
        READY = 1'b1;
        tick();
        chk("gate_gnt", 32'(GNT), 32'h1);
        chk("gate_cmd_wr", 32'(CMD), 32'h2);
        chk("gate_addr", 32'(ADDR), 32'h7);
        CMD_ACK = 1'b1;
        tick();
        chk("gate_ack1", 32'({ACK1, ACK0}), 32'h2);
        CMD_ACK = 1'b0; REQ1 = 1'b0;
        tick();

        // contention, ACK two cycles after each grant
        REQ0 = 1'b1; REQ1 = 1'b1; WR0 = 1'b0; WR1 = 1'b1;
        ADDR0 = 23'h100; ADDR1 = 23'h200;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            eg = (i % 2) == 1;
`else
            eg = 1'b0;
`endif
            tick();
            chk("cont_gnt", 32'(GNT), 32'(eg));
            chk("cont_cmd", 32'(CMD), eg ? 32'h2 : 32'h1);
            chk("cont_addr", 32'(ADDR), eg ? 32'h200 : 32'h100);
            tick();
            CMD_ACK = 1'b1;
            tick();
            chk("cont_ack", 32'({ACK1, ACK0}), eg ? 32'h2 : 32'h1);
            CMD_ACK = 1'b0;
            tick();
            chk("cont_gap_idle", 32'(BUSY), 32'h0);
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
        chk("cont_no_grant", 32'(BUSY), 32'h0);

        // watchdog timeout
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 23'h55;
        tick();
        chk("to_cmd", 32'(CMD), 32'h2);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_no_err", 32'(ERR), 32'h0);
            chk("to_cmd_hold", 32'(CMD), 32'h2);
        end
        tick();
        chk("to_err", 32'(ERR), 32'h1);
        chk("to_no_ack", 32'({ACK1, ACK0}), 32'h0);
        chk("to_cmd_nop", 32'(CMD), 32'h0);
        chk("to_gnt", 32'(GNT), 32'h0);
        REQ0 = 1'b0;
        tick();
        chk("to_err_pulse", 32'(ERR), 32'h0);
        chk("to_idle", 32'(BUSY), 32'h0);

        // ack coincident with the timeout cycle
        REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 23'h66;
        tick();
        chk("sim_gnt", 32'(GNT), 32'h1);
        chk("sim_cmd", 32'(CMD), 32'h1);
        for (int i = 0; i < 8; i++) tick();
        CMD_ACK = 1'b1;
        tick();
        chk("sim_ack1", 32'(ACK1), 32'h1);
        chk("sim_no_err", 32'(ERR), 32'h0);
        CMD_ACK = 1'b0; REQ1 = 1'b0;
        tick();
        CMD_ACK = 1'b1;
        tick();
        chk("stray_cmd", 32'(CMD), 32'h0);
        chk("stray_busy", 32'(BUSY), 32'h0);
        chk("stray_acks", 32'({ACK1, ACK0, ERR}), 32'h0);
        chk("stray_gnt", 32'(GNT), 32'h1);
        CMD_ACK = 1'b0;

        // asynchronous reset in WAIT
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 23'h9;
        tick();
        chk("rw_cmd", 32'(CMD), 32'h2);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rw_cmd_rst", 32'(CMD), 32'h0);
        chk("rw_busy_rst", 32'(BUSY), 32'h0);
        chk("rw_addr_rst", 32'(ADDR), 32'h0);
        REQ0 = 1'b0;
        tick();
        chk("rw_no_ack", 32'({ACK1, ACK0, ERR}), 32'h0);
        RESET_N = 1'b1;
        REQ0 = 1'b1; REQ1 = 1'b1; WR0 = 1'b0; WR1 = 1'b0;
        tick();
        chk("rw_first_gnt", 32'(GNT), 32'h0);
        chk("rw_first_cmd", 32'(CMD), 32'h1);
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
